// File: rtl/vector_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// vector_fetch_unit_if
//   Bundles the vector fetch unit's memory read port and its program-counter
//   load port.
//   Memory side : addr_out, mem_rd (unit -> memory), data_in (memory -> unit).
//                 The memory returns data_in one cycle after the read strobe.
//   PC side     : PCL_out, PCH_out, pc_load (unit -> PC).
//   master modport : the fetch unit.
//   slave modport  : the memory / PC side.
// ---------------------------------------------------------------------------
interface vector_fetch_unit_if;
  logic [15:0] addr_out;
  logic        mem_rd;
  logic [7:0]  data_in;
  logic [7:0]  PCL_out;
  logic [7:0]  PCH_out;
  logic        pc_load;

  modport master (
    output addr_out, mem_rd, PCL_out, PCH_out, pc_load,
    input  data_in
  );

  modport slave (
    input  addr_out, mem_rd, PCL_out, PCH_out, pc_load,
    output data_in
  );
endinterface

// File: rtl/vector_fetch_unit.sv
// ---------------------------------------------------------------------------
// vector_fetch_unit
//   Feeds the program counter. The unit reads the 16-bit reset, NMI or IRQ
//   vector from memory and hands it to the PC with a one-cycle load strobe.
//   At instruction boundaries it arbitrates between two interrupt sources:
//   NMI is edge-triggered and always wins, and IRQ is level-sensitive and
//   maskable. The core is stalled through busy for the whole fetch.
//
//   Ports:
//     clk            system clock, rising edge
//     reset          synchronous, active-high reset
//     nmi_n          NMI line, active low, falling-edge triggered
//     irq_n          IRQ line, active low, level sensitive
//     i_flag         interrupt-disable flag (1 = IRQ masked)
//     instr_boundary core is between instructions
//     bus            memory read port + PC load port (master side)
//     busy           fetch in progress or about to start; the core must stall
//     svc_kind       00 none, 01 reset, 10 nmi, 11 irq
// ---------------------------------------------------------------------------
module vector_fetch_unit #(
  parameter logic [15:0] NMI_VEC   = 16'hFFFA,
  parameter logic [15:0] RESET_VEC = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC   = 16'hFFFE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       nmi_n,
  input  logic                       irq_n,
  input  logic                       i_flag,
  input  logic                       instr_boundary,
  vector_fetch_unit_if.master        bus,
  output logic                       busy,
  output logic [1:0]                 svc_kind
);

  typedef enum logic [2:0] {
    S_START,
    S_LO,
    S_HI,
    S_DONE,
    S_IDLE
  } state_t;

  typedef enum logic [1:0] {
    SVC_NONE  = 2'b00,
    SVC_RESET = 2'b01,
    SVC_NMI   = 2'b10,
    SVC_IRQ   = 2'b11
  } svc_t;

  state_t      state, state_nxt;
  svc_t        svc_q, svc_nxt;
  logic        nmi_prev;
  logic        nmi_pending;
  logic        nmi_take;
  logic        nmi_fell;
  logic [7:0]  lo_reg;
  logic [15:0] vec;

  assign svc_kind = svc_q;
  assign nmi_fell = nmi_prev & ~nmi_n;

  // The vector address follows the service being handled. SVC_NONE only
  // occurs in S_IDLE, where no address is driven.
  always_comb begin
    unique case (svc_q)
      SVC_NMI: vec = NMI_VEC;
      SVC_IRQ: vec = IRQ_VEC;
      default: vec = RESET_VEC;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_START;
      svc_q       <= SVC_RESET;
      nmi_pending <= 1'b0;
      nmi_prev    <= 1'b1;
      lo_reg      <= 8'h00;
    end else begin
      state    <= state_nxt;
      svc_q    <= svc_nxt;
      nmi_prev <= nmi_n;
      // A new falling edge in the cycle of acceptance must not be lost, so
      // setting takes priority over clearing.
      if (nmi_fell)
        nmi_pending <= 1'b1;
      else if (nmi_take)
        nmi_pending <= 1'b0;
      if (state == S_HI)
        lo_reg <= bus.data_in;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    svc_nxt      = svc_q;
    nmi_take     = 1'b0;
    busy         = (state != S_IDLE);
    bus.addr_out = 16'h0000;
    bus.mem_rd   = 1'b0;
    bus.PCL_out  = 8'h00;
    bus.PCH_out  = 8'h00;
    bus.pc_load  = 1'b0;

    unique case (state)
      S_START: begin
        state_nxt = S_LO;
      end
      S_LO: begin
        bus.addr_out = vec;
        bus.mem_rd   = 1'b1;
        state_nxt    = S_HI;
      end
      S_HI: begin
        bus.addr_out = vec + 16'd1;
        bus.mem_rd   = 1'b1;
        state_nxt    = S_DONE;
      end
      S_DONE: begin
        // The high byte arrives on data_in this cycle and goes straight to
        // the PC. The low byte was captured during S_HI.
        bus.PCL_out = lo_reg;
        bus.PCH_out = bus.data_in;
        bus.pc_load = 1'b1;
        svc_nxt     = SVC_NONE;
        state_nxt   = S_IDLE;
      end
      S_IDLE: begin
        if (instr_boundary) begin
          if (nmi_pending) begin
            svc_nxt   = SVC_NMI;
            nmi_take  = 1'b1;
            state_nxt = S_LO;
          end else if (!irq_n && !i_flag) begin
            svc_nxt   = SVC_IRQ;
            state_nxt = S_LO;
          end
        end
      end
      default: begin
        state_nxt = S_START;
      end
    endcase
  end

endmodule

// File: tb/tb_vector_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_vector_fetch_unit
//   Directed testbench for vector_fetch_unit. A behavioural model counts the
//   cycles since each fetch began and derives every output from that count
//   and from the vector table. The outputs are compared against the model on
//   every falling edge. Directed scenarios add literal expectations for the
//   loaded vectors, the service kinds and the number of loads.
// ---------------------------------------------------------------------------
module tb_vector_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       nmi_n = 1'b1;
  logic       irq_n = 1'b1;
  logic       i_flag = 1'b1;
  logic       instr_boundary = 1'b0;
  logic       busy;
  logic [1:0] svc_kind;

  always #5 clk = ~clk;

  vector_fetch_unit_if bus ();

  vector_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .nmi_n          (nmi_n),
    .irq_n          (irq_n),
    .i_flag         (i_flag),
    .instr_boundary (instr_boundary),
    .bus            (bus),
    .busy           (busy),
    .svc_kind       (svc_kind)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Vector table at FFFA..FFFF: NMI=1234, RESET=8000, IRQ=5678.
  logic [7:0] vmem [6];

  function automatic logic [7:0] rd_byte(input logic [15:0] a);
    int idx;
    idx = int'(a) - 32'hFFFA;
    if (idx >= 0 && idx < 6) return vmem[idx];
    return 8'hDD;
  endfunction

  function automatic logic [15:0] vec_of(input int kind);
    case (kind)
      2:       return 16'hFFFA;
      3:       return 16'hFFFE;
      default: return 16'hFFFC;
    endcase
  endfunction

  // Memory: data is returned one cycle after the read strobe, and a junk value
  // is returned when there was no read.
  always @(posedge clk)
    bus.data_in <= (bus.mem_rd === 1'b1) ? rd_byte(bus.addr_out) : 8'hEE;

  // Model. m_cyc is the number of cycles since the fetch began: 0 is the
  // start cycle after reset, 1 and 2 are the two reads, 3 is the load, and -1
  // is idle.
  int   m_cyc = -1;
  int   m_kind = 0;
  logic m_pend = 1'b0;
  logic m_last = 1'b1;
  bit   m_valid = 1'b0;

  always @(posedge clk) begin
    bit fell;
    if (reset) begin
      m_cyc   = 0;
      m_kind  = 1;
      m_pend  = 1'b0;
      m_last  = 1'b1;
      m_valid = 1'b1;
    end else if (m_valid) begin
      fell   = m_last && !nmi_n;
      m_last = nmi_n;
      if (m_cyc >= 0 && m_cyc < 3) begin
        m_cyc = m_cyc + 1;
      end else if (m_cyc == 3) begin
        m_cyc  = -1;
        m_kind = 0;
      end else if (instr_boundary) begin
        if (m_pend) begin
          m_kind = 2;
          m_pend = 1'b0;
          m_cyc  = 1;
        end else if (!irq_n && !i_flag) begin
          m_kind = 3;
          m_cyc  = 1;
        end
      end
      if (fell) m_pend = 1'b1;
    end
  end

  // Compare process and load monitor.
  int          load_cnt = 0;
  logic [15:0] last_vec = 16'h0000;
  logic [1:0]  last_kind = 2'b00;

  always @(negedge clk) begin
    logic [15:0] v;
    if (m_valid) begin
      v = vec_of(m_kind);
      check("busy", 32'(busy), 32'(m_cyc != -1));
      check("svc_kind", 32'(svc_kind), 32'(m_kind));
      check("mem_rd", 32'(bus.mem_rd), 32'(m_cyc == 1 || m_cyc == 2));
      check("pc_load", 32'(bus.pc_load), 32'(m_cyc == 3));
      if (m_cyc == 1 || m_cyc == 2)
        check("addr_out", 32'(bus.addr_out), 32'(v + 16'(m_cyc - 1)));
      if (m_cyc == 0 || m_cyc == -1) begin
        check("addr_out idle", 32'(bus.addr_out), 32'h0);
        check("PC bytes idle", 32'({bus.PCH_out, bus.PCL_out}), 32'h0);
      end
      if (m_cyc == 3)
        check("PC vector", 32'({bus.PCH_out, bus.PCL_out}),
              32'({rd_byte(v + 16'd1), rd_byte(v)}));
    end
    if (bus.pc_load === 1'b1) begin
      load_cnt++;
      last_vec  = {bus.PCH_out, bus.PCL_out};
      last_kind = svc_kind;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_boundary();
    instr_boundary = 1'b1;
    step(1);
    instr_boundary = 1'b0;
  endtask

  task automatic wait_load(input int exp_cnt, input logic [15:0] exp_vec,
                           input logic [1:0] exp_kind, input string name);
    int n = 0;
    while (load_cnt < exp_cnt && n < 30) begin
      step(1);
      n++;
    end
    check({name, " load count"}, 32'(load_cnt), 32'(exp_cnt));
    check({name, " vector"}, 32'(last_vec), 32'(exp_vec));
    check({name, " kind"}, 32'(last_kind), 32'(exp_kind));
  endtask

  task automatic wait_addr(input logic [15:0] a, input string name);
    int n = 0;
    while (!(bus.mem_rd === 1'b1 && bus.addr_out === a) && n < 20) begin
      step(1);
      n++;
    end
    check(name, 32'(bus.addr_out), 32'(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vmem[0] = 8'h34; vmem[1] = 8'h12;
    vmem[2] = 8'h00; vmem[3] = 8'h80;
    vmem[4] = 8'h78; vmem[5] = 8'h56;

    // Reset state, then the reset-vector fetch with its 3-cycle latency.
    step(3);
    check("reset busy", 32'(busy), 32'h1);
    check("reset svc_kind", 32'(svc_kind), 32'h1);
    check("reset mem_rd", 32'(bus.mem_rd), 32'h0);
    reset = 1'b0;
    step(1);
    check("reset lo addr", 32'(bus.addr_out), 32'hFFFC);
    step(1);
    check("reset hi addr", 32'(bus.addr_out), 32'hFFFD);
    step(1);
    check("reset pc_load", 32'(bus.pc_load), 32'h1);
    check("reset vector", 32'({bus.PCH_out, bus.PCL_out}), 32'h8000);
    step(1);
    check("post-reset busy", 32'(busy), 32'h0);
    check("post-reset svc_kind", 32'(svc_kind), 32'h0);
    check("reset load count", 32'(load_cnt), 32'h1);

    // NMI from idle, then nmi_n held low: exactly one service.
    nmi_n = 1'b0;
    step(1);
    pulse_boundary();
    wait_load(2, 16'h1234, 2'b10, "nmi");
    for (int i = 0; i < 5; i++) begin
      step(3);
      pulse_boundary();
    end
    check("nmi held single service", 32'(load_cnt), 32'h2);
    nmi_n = 1'b1;
    step(2);

    // A masked IRQ is ignored, then unmasked it is served.
    irq_n = 1'b0;
    i_flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse_boundary();
      step(1);
    end
    check("masked irq no fetch", 32'(load_cnt), 32'h2);
    i_flag = 1'b0;
    pulse_boundary();
    wait_load(3, 16'h5678, 2'b11, "irq");
    irq_n = 1'b1;
    step(2);

    // NMI and IRQ both present at one boundary: NMI first, then IRQ.
    nmi_n = 1'b0;
    irq_n = 1'b0;
    step(1);
    pulse_boundary();
    wait_load(4, 16'h1234, 2'b10, "nmi over irq");
    step(1);
    pulse_boundary();
    wait_load(5, 16'h5678, 2'b11, "irq after nmi");
    irq_n = 1'b1;
    nmi_n = 1'b1;
    step(2);

    // NMI edge during the high-byte read of an IRQ fetch.
    irq_n = 1'b0;
    pulse_boundary();
    wait_addr(16'hFFFF, "irq hi read");
    nmi_n = 1'b0;
    irq_n = 1'b1;
    wait_load(6, 16'h5678, 2'b11, "irq with nmi in flight");
    step(1);
    pulse_boundary();
    wait_load(7, 16'h1234, 2'b10, "nmi after irq");
    nmi_n = 1'b1;
    step(2);

    // Reset during S_HI with an NMI pending: abort, refetch, pending cleared.
    irq_n = 1'b0;
    pulse_boundary();
    wait_addr(16'hFFFE, "irq lo read");
    nmi_n = 1'b0;
    irq_n = 1'b1;
    step(1);
    check("in hi read", 32'(bus.addr_out), 32'hFFFF);
    reset = 1'b1;
    nmi_n = 1'b1;
    step(2);
    check("no load across reset", 32'(load_cnt), 32'h7);
    check("svc_kind in reset", 32'(svc_kind), 32'h1);
    reset = 1'b0;
    wait_load(8, 16'h8000, 2'b01, "refetch after reset");
    step(1);
    pulse_boundary();
    step(2);
    pulse_boundary();
    step(3);
    check("nmi pending cleared by reset", 32'(load_cnt), 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
